// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide co-processor.
// Holds the op codes, the FSM state codes and the iteration-counter width helper.
package alu_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_RUN   = 2'd1;
  localparam logic [1:0] MD_FIX   = 2'd2;
  localparam logic [1:0] MD_DONE  = 2'd3;

  localparam int MD_N_DEF = 32;

  // Counter width: clog2 of the operand width, never narrower than one bit.
  function automatic int md_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// In divide mode sreg_nxt shifts in 0; the caller merges q_bit into its LSB.
module muldiv_step #(
  parameter int N = 32
) (
  input  logic         div_mode,
  input  logic [N-1:0] acc,
  input  logic [N-1:0] sreg,
  input  logic [N-1:0] opnd,
  output logic [N-1:0] acc_nxt,
  output logic [N-1:0] sreg_nxt,
  output logic         q_bit
);

  logic [N:0] sum;
  logic [N:0] addend;
  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, opnd};
    addend   = sreg[0] ? sum : {1'b0, acc};
    shifted  = {acc, sreg[N-1]};
    diff     = shifted - {1'b0, opnd};
    q_bit    = 1'b0;
    acc_nxt  = addend[N:1];
    sreg_nxt = {addend[0], sreg[N-1:1]};
    if (div_mode) begin
      // diff[N] is the borrow: clear means the partial remainder covers the divisor.
      q_bit    = ~diff[N];
      acc_nxt  = q_bit ? diff[N-1:0] : shifted[N-1:0];
      sreg_nxt = {sreg[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers, start/busy/done handshake.
// Optional MULDIV_EARLY_OUT_EN: early multiply exit and RUN bypass on divide by zero.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// RUN   | one radix-2 step per cycle, counter counts down to 0
// FIX   | sign fixup on magnitudes; HI/LO written on exit
// DONE  | done pulse, back to IDLE
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int N       = MD_N_DEF,
  parameter int OP_SIZE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [OP_SIZE-1:0] op,
  input  logic [N-1:0]       ADin,
  input  logic [N-1:0]       BDin,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [N-1:0]       HI,
  output logic [N-1:0]       LO
);

  localparam int CNT_W = md_cnt_w(N);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [OP_SIZE-1:0] op_q;
  logic [N-1:0]       a_raw;
  logic [N-1:0]       acc;
  logic [N-1:0]       sreg;
  logic [N-1:0]       opnd;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;

  logic               in_signed, in_div, is_div, neg_res;
  logic [N-1:0]       mag_a, mag_b;
  logic [N-1:0]       step_acc, step_sreg;
  logic               step_q;
  logic [2*N-1:0]     prod, prod_fix;
  logic [N-1:0]       quot_fix, rem_fix;

  always_comb begin
    in_signed = (op == OP_SIZE'(MD_MULT)) || (op == OP_SIZE'(MD_DIV));
    in_div    = (op == OP_SIZE'(MD_DIV))  || (op == OP_SIZE'(MD_DIVU));
    is_div    = (op_q == OP_SIZE'(MD_DIV)) || (op_q == OP_SIZE'(MD_DIVU));
    // Unary minus on the most negative value yields 2^(N-1) as an unsigned magnitude.
    mag_a     = (in_signed && ADin[N-1]) ? -ADin : ADin;
    mag_b     = (in_signed && BDin[N-1]) ? -BDin : BDin;
    neg_res   = sign_a ^ sign_b;
    prod      = {acc, sreg};
    prod_fix  = neg_res ? -prod : prod;
    quot_fix  = neg_res ? -sreg : sreg;
    rem_fix   = sign_a ? -acc : acc;
  end

  muldiv_step #(.N(N)) u_step (
    .div_mode (is_div),
    .acc      (acc),
    .sreg     (sreg),
    .opnd     (opnd),
    .acc_nxt  (step_acc),
    .sreg_nxt (step_sreg),
    .q_bit    (step_q)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W:0] rem_bits;
  logic [N-1:0]   rem_mask;
  logic           mul_rem_zero;

  // The unconsumed multiplier bits sit in the low cnt+1 positions of sreg.
  always_comb begin
    rem_bits     = (CNT_W+1)'(cnt) + (CNT_W+1)'(1);
    rem_mask     = ~({N{1'b1}} << rem_bits);
    mul_rem_zero = ((sreg & rem_mask) == '0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      a_raw       <= '0;
      acc         <= '0;
      sreg        <= '0;
      opnd        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q        <= op;
            a_raw       <= ADin;
            sign_a      <= in_signed & ADin[N-1];
            sign_b      <= in_signed & BDin[N-1];
            b_zero      <= (BDin == '0);
            acc         <= '0;
            sreg        <= in_div ? mag_a : mag_b;
            opnd        <= in_div ? mag_b : mag_a;
            div_by_zero <= 1'b0;
            cnt         <= CNT_W'(N-1);
            state       <= MD_RUN;
`ifdef MULDIV_EARLY_OUT_EN
            if (in_div && (BDin == '0)) state <= MD_FIX;
`endif
          end
        end
        MD_RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (!is_div && mul_rem_zero) begin
            {acc, sreg} <= prod >> rem_bits;
            state       <= MD_FIX;
          end else
`endif
          begin
            acc  <= step_acc;
            sreg <= {step_sreg[N-1:1], step_sreg[0] | step_q};
            if (cnt == '0) state <= MD_FIX;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        MD_FIX: begin
          if (is_div && b_zero) begin
            HI          <= a_raw;
            LO          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            HI <= rem_fix;
            LO <= quot_fix;
          end else begin
            HI <= prod_fix[2*N-1:N];
            LO <= prod_fix[N-1:0];
          end
          state <= MD_DONE;
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state != MD_IDLE);
  assign done = (state == MD_DONE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: directed ops push expected HI/LO/flag, a monitor checks on done.
module tb_alu_muldiv_seq;
  import alu_muldiv_pkg::*;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [N-1:0]  ADin = '0;
  logic [N-1:0]  BDin = '0;
  logic          busy, done, div_by_zero;
  logic [N-1:0]  HI, LO;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
    int           tag;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_count = 0;
  int   tag_next = 0;

  alu_muldiv_seq #(.N(N), .OP_SIZE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .ADin        (ADin),
    .BDin        (BDin),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("HI[%0d]", e.tag), HI, e.hi);
          chk($sformatf("LO[%0d]", e.tag), LO, e.lo);
          chk($sformatf("dbz[%0d]", e.tag), {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] ehi, input logic [N-1:0] elo, input logic edbz,
                        input int inject);
    int cyc;
    bit seen, busy_ok;
    int dc0;
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.tag = tag_next;
    sb_q.push_back(e);
    dc0 = done_count;
    @(negedge clk);
    op = o; ADin = a; BDin = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("dbz_clear_on_start[%0d]", tag_next), {31'd0, div_by_zero}, 32'd0);
    cyc = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
      else if (inject != 0 && cyc == inject) begin
        start = 1'b1; op = MD_DIVU; ADin = ~a; BDin = b + 32'd3;
      end else start = 1'b0;
    end
    chk($sformatf("done_seen[%0d]", tag_next), {31'd0, seen}, 32'd1);
    chk($sformatf("latency[%0d]", tag_next), cyc, N + 2);
    chk($sformatf("busy_throughout[%0d]", tag_next), {31'd0, busy_ok}, 32'd1);
    // start in the DONE cycle must be dropped and leave HI/LO alone
    start = 1'b1; op = MD_DIVU; ADin = 32'h0000DEAD; BDin = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("start_in_done_ignored[%0d]", tag_next), {31'd0, busy}, 32'd0);
    chk($sformatf("hi_hold[%0d]", tag_next), HI, ehi);
    chk($sformatf("lo_hold[%0d]", tag_next), LO, elo);
    repeat (3) @(negedge clk);
    chk($sformatf("one_done_pulse[%0d]", tag_next), done_count - dc0, 32'd1);
    tag_next++;
  endtask

  initial begin
    int dc0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
    run_op(MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
    run_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run_op(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
    run_op(MD_MULT,  32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000000, 32'h00000020, 1'b0, 0);
    run_op(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0);
    run_op(MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 0);
    run_op(MD_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1, 0);
    run_op(MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0);
    run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
    run_op(MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 0);
    run_op(MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 5);

    // Reset in the middle of RUN aborts without a done pulse.
    dc0 = done_count;
    @(negedge clk);
    op = MD_MULTU; ADin = 32'h1234; BDin = 32'h5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 10) @(negedge clk);
    chk("midrst_no_done", done_count - dc0, 32'd0);

    run_op(MD_MULTU, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
